dmem_wait: RTL

Parametrised data-memory model with a busywait handshake. It supports a configurable depth and access latency, and byte, halfword and word loads and stores with sign or zero extension. It sits on the CPU's MA-stage memory port (DMEM_READ_MA, DMEM_WRITE_MA, DMEM_ADDR_MA, DMEM_DATA_WRITE_MA, DMEM_DATA_READ_MA, BUSYWAIT_IN). Benches and the FPGA top use it to exercise pipeline stalls under variable memory latency.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_fmt.sv | 81 ++++++++
 rtl/dmem_wait.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the dmem_wait data-memory model: load funct3 codes,
// store sizes, FSM states and the latency counter width.
package dmem_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for dmem_wait: load extraction with sign/zero extension,
// store byte-enable and lane replication, and misalignment detection.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        load_ok,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic        store_ok,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        ld_mis;
    logic        st_mis;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        sel_byte  = word[7:0];
        sel_half  = byte_off[1] ? word[31:16] : word[15:0];
        load_data = '0;
        load_ok   = 1'b1;

        case (byte_off)
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            2'd3:    sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase

        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {24'b0, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {16'b0, sel_half};
            F3_LW:   load_data = word;
            default: load_ok   = 1'b0;
        endcase
    end

    // Narrow store data is replicated into every lane; byte_en picks the live ones.
    always_comb begin
        byte_en    = '0;
        store_word = wdata;
        store_ok   = 1'b1;
        case (size)
            SZ_B: begin
                byte_en    = 4'b0001 << byte_off;
                store_word = {4{wdata[7:0]}};
            end
            SZ_H: begin
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata[15:0]}};
            end
            SZ_W: begin
                byte_en    = 4'b1111;
                store_word = wdata;
            end
            default: store_ok = 1'b0;
        endcase
    end

    always_comb begin
        ld_mis   = ((funct3 == F3_LH || funct3 == F3_LHU) && byte_off[0]) ||
                   (funct3 == F3_LW && byte_off != 2'b00);
        st_mis   = (size == SZ_H && byte_off[0]) ||
                   (size == SZ_W && byte_off != 2'b00);
        misalign = (rd_en && ld_mis) || (wr_en && st_mis);
    end

endmodule

// File: rtl/dmem_wait.sv
// Data-memory model with a busywait handshake and configurable latency.
// Define DMEM_MISALIGN_EN to trap misaligned accesses instead of force-aligning them.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        ERR
);

    localparam int               DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             access;

    logic             rd_en, wr_en, req;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]      mem [DEPTH];

    logic [31:0]      load_data, store_word;
    logic [3:0]       byte_en;
    logic             load_ok, store_ok, misalign, misalign_err;
    logic             err_now, mem_we;
    logic [31:0]      rdata_next;
    logic             unused_bits;

    assign rd_en    = READ[3];
    assign wr_en    = WRITE[2];
    assign req      = rd_en | wr_en;
    assign word_idx = ADDRESS[DEPTH_LOG2+1:2];

    dmem_lane_fmt u_lane_fmt (
        .funct3     (READ[2:0]),
        .size       (WRITE[1:0]),
        .byte_off   (ADDRESS[1:0]),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .word       (mem[word_idx]),
        .wdata      (WRITEDATA),
        .load_data  (load_data),
        .load_ok    (load_ok),
        .byte_en    (byte_en),
        .store_word (store_word),
        .store_ok   (store_ok),
        .misalign   (misalign)
    );

`ifdef DMEM_MISALIGN_EN
    assign misalign_err = misalign;
    assign unused_bits  = ^ADDRESS[31:DEPTH_LOG2+2];
`else
    assign misalign_err = 1'b0;
    assign unused_bits  = ^{ADDRESS[31:DEPTH_LOG2+2], misalign};
`endif

    // The counter hits zero on the edge that performs the access; with
    // LATENCY==1 that edge is the one leaving IDLE, so BUSY is skipped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LOAD_VAL;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSYWAIT = (state_q == IDLE && req) || (state_q == BUSY);

    always_comb begin
        err_now    = (rd_en && wr_en) || (wr_en && !store_ok) ||
                     (rd_en && !load_ok) || misalign_err;
        mem_we     = access && wr_en && store_ok && !misalign_err;
        rdata_next = (rd_en && !wr_en && load_ok && !misalign_err) ? load_data : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            READDATA <= '0;
            ERR      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ERR     <= access && err_now;
            if (access && rd_en) begin
                READDATA <= rdata_next;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive RST, and a write
    // coinciding with RST is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

endmodule
